// File: rtl/oldland_bus_pkg.sv
// Shared definitions for the Oldland instruction/data bus arbiter.
//   bus_state_t  : arbiter FSM encoding (2 bits)
//   GRANT_I/D    : encoding of the round-robin grant history bit
//   BYTESEL_ALL  : byte enables driven for instruction fetches
package oldland_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } bus_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [3:0] BYTESEL_ALL = 4'b1111;

endpackage

// File: rtl/oldland_bus_timeout.sv
// Transaction watchdog for the shared memory bus.
//   clk     : system clock
//   rst     : synchronous active-low reset
//   clear   : restart the count (asserted on every new grant)
//   enable  : count this cycle (bus request outstanding, no ack)
//   expired : count has reached timeout_cycles - 1
module oldland_bus_timeout
  import oldland_bus_pkg::*;
#(
  parameter int timeout_cycles = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(timeout_cycles);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(timeout_cycles - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // The arbiter leaves BUSY on the cycle after expiry, so the counter never
  // needs to wrap or saturate past LAST.
  assign expired = (count == LAST);

endmodule

// File: rtl/oldland_bus_arbiter.sv
// Round-robin arbiter merging the pipeline instruction bus (i_*) and data
// bus (d_*) onto the shared memory bus (m_*). The granted request is
// registered onto m_*, and the completion (ack, read data, error) is routed
// back to the requester one cycle after m_ack. A watchdog turns a hung
// slave into a bus error on the requester.
//   clk, rst                 : clock, synchronous active-low reset
//   i_access/i_addr          : instruction request (level, held until i_ack)
//   i_data/i_ack/i_error     : instruction completion
//   d_access/d_addr/d_bytesel/d_wr_en/d_wr_val : data request
//   d_data/d_ack/d_error     : data completion
//   m_access/m_addr/m_bytesel/m_wr_en/m_wr_val : registered shared bus request
//   m_data/m_ack/m_error     : shared bus slave response
module oldland_bus_arbiter
  import oldland_bus_pkg::*;
#(
  parameter int timeout_cycles = 255,
  parameter bit d_first        = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_access,
  input  logic [29:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_ack,
  output logic        i_error,
  input  logic        d_access,
  input  logic [29:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,
  output logic        m_access,
  output logic [29:0] m_addr,
  output logic [3:0]  m_bytesel,
  output logic        m_wr_en,
  output logic [31:0] m_wr_val,
  input  logic [31:0] m_data,
  input  logic        m_ack,
  input  logic        m_error
);

  bus_state_t  state, state_n;
  logic        last_grant, last_grant_n;
  logic        m_access_n;
  logic [29:0] m_addr_n;
  logic [3:0]  m_bytesel_n;
  logic        m_wr_en_n;
  logic [31:0] m_wr_val_n;
  logic [31:0] i_data_n, d_data_n;
  logic        i_ack_n, d_ack_n, i_error_n, d_error_n;

  logic        grant;
  logic        sel;
  logic        expired;
  logic [31:0] rsp_data;
  logic        rsp_err;

  oldland_bus_timeout #(
    .timeout_cycles(timeout_cycles)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant),
    .enable (m_access & ~m_ack),
    .expired(expired)
  );

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    m_access_n   = m_access;
    m_addr_n     = m_addr;
    m_bytesel_n  = m_bytesel;
    m_wr_en_n    = m_wr_en;
    m_wr_val_n   = m_wr_val;
    i_data_n     = i_data;
    i_error_n    = i_error;
    i_ack_n      = 1'b0;
    d_data_n     = d_data;
    d_error_n    = d_error;
    d_ack_n      = 1'b0;
    grant        = 1'b0;
    sel          = GRANT_I;
    // A real ack beats a simultaneous expiry; a timeout returns zero data.
    rsp_data     = m_ack ? m_data : 32'h0;
    rsp_err      = m_ack ? m_error : 1'b1;

    case (state)
      ST_IDLE: begin
        if (i_access || d_access) begin
          grant = 1'b1;
          if (i_access && d_access) begin
            sel = ~last_grant;
          end else if (d_access) begin
            sel = GRANT_D;
          end
          last_grant_n = sel;
          m_access_n   = 1'b1;
          if (sel == GRANT_D) begin
            state_n     = ST_BUSY_D;
            m_addr_n    = d_addr;
            m_bytesel_n = d_bytesel;
            m_wr_en_n   = d_wr_en;
            m_wr_val_n  = d_wr_val;
          end else begin
            state_n     = ST_BUSY_I;
            m_addr_n    = i_addr;
            m_bytesel_n = BYTESEL_ALL;
            m_wr_en_n   = 1'b0;
            m_wr_val_n  = 32'h0;
          end
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // Requester inputs are deliberately not looked at here.
        if (m_ack || expired) begin
          m_access_n = 1'b0;
          state_n    = ST_RESP;
          if (state == ST_BUSY_D) begin
            d_ack_n   = 1'b1;
            d_data_n  = rsp_data;
            d_error_n = rsp_err;
          end else begin
            i_ack_n   = 1'b1;
            i_data_n  = rsp_data;
            i_error_n = rsp_err;
          end
        end
      end
      ST_RESP: begin
        // The served client still holds its request this cycle; ignore it.
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_grant <= d_first ? GRANT_I : GRANT_D;
      m_access   <= 1'b0;
      m_addr     <= '0;
      m_bytesel  <= '0;
      m_wr_en    <= 1'b0;
      m_wr_val   <= '0;
      i_data     <= '0;
      i_ack      <= 1'b0;
      i_error    <= 1'b0;
      d_data     <= '0;
      d_ack      <= 1'b0;
      d_error    <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      m_access   <= m_access_n;
      m_addr     <= m_addr_n;
      m_bytesel  <= m_bytesel_n;
      m_wr_en    <= m_wr_en_n;
      m_wr_val   <= m_wr_val_n;
      i_data     <= i_data_n;
      i_ack      <= i_ack_n;
      i_error    <= i_error_n;
      d_data     <= d_data_n;
      d_ack      <= d_ack_n;
      d_error    <= d_error_n;
    end
  end

endmodule

// File: tb/tb_oldland_bus_arbiter.sv
// Self-checking bench for oldland_bus_arbiter: directed scenarios followed by
// randomized traffic from both clients, a behavioural slave, and a monitor
// that checks the bus protocol cycle by cycle against a scoreboard.
module tb_oldland_bus_arbiter;

  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_access, d_access, d_wr_en;
  logic [29:0] i_addr, d_addr;
  logic [3:0]  d_bytesel;
  logic [31:0] d_wr_val;
  logic [31:0] i_data, d_data;
  logic        i_ack, i_error, d_ack, d_error;
  logic        m_access, m_wr_en;
  logic [29:0] m_addr;
  logic [3:0]  m_bytesel;
  logic [31:0] m_wr_val;
  logic [31:0] m_data;
  logic        m_ack, m_error;

  always #5 clk = ~clk;

  oldland_bus_arbiter #(.timeout_cycles(TO), .d_first(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_access(i_access), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack), .i_error(i_error),
    .d_access(d_access), .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_en(d_wr_en),
    .d_wr_val(d_wr_val), .d_data(d_data), .d_ack(d_ack), .d_error(d_error),
    .m_access(m_access), .m_addr(m_addr), .m_bytesel(m_bytesel), .m_wr_en(m_wr_en),
    .m_wr_val(m_wr_val), .m_data(m_data), .m_ack(m_ack), .m_error(m_error)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic        err;
    int          late;
  } plan_t;
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  plan_t plan_q[$];
  resp_t resp_q[$];
  bit    grant_q[$];
  bit    spur_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- slave model ----------------
  int          s_hi = 0, s_lat = 0, s_late = 0, s_plate = 0;
  logic [31:0] s_data;
  logic        s_err;
  initial begin
    m_ack = 1'b0; m_error = 1'b0; m_data = 32'h0;
    forever begin
      tick();
      m_ack = 1'b0; m_error = 1'b0; m_data = $urandom;
      if (m_access) begin
        if (s_hi == 0) begin
          if (plan_q.size() > 0) begin
            plan_t p;
            p = plan_q.pop_front();
            s_lat = p.lat; s_data = p.data; s_err = p.err; s_plate = p.late;
          end else begin
            s_lat   = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TO - 1));
            s_data  = $urandom;
            s_err   = ($urandom_range(0, 5) == 0);
            s_plate = 0;
          end
        end
        if (s_hi == s_lat) begin
          m_ack = 1'b1; m_data = s_data; m_error = s_err;
          resp_q.push_back('{data: s_data, err: s_err});
        end else if (s_hi == TO - 1) begin
          resp_q.push_back('{data: 32'h0, err: 1'b1});
          s_late = s_plate;
        end
        s_hi++;
      end else begin
        s_hi = 0;
        if (s_late > 0) begin
          s_late--;
          if (s_late == 0) begin
            m_ack = 1'b1; m_error = 1'b1;
          end
        end else if (spur_en && $urandom_range(0, 3) == 0) begin
          m_ack = 1'b1; m_error = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // ---------------- monitor / reference model ----------------
  // p_* hold what the DUT sampled at the edge just before this negedge.
  logic        p_rst = 1'b0, p_i = 1'b0, p_d = 1'b0, p_macc = 1'b0, p_mack = 1'b0, p_we = 1'b0;
  logic [29:0] p_ia = '0, p_da = '0;
  logic [3:0]  p_bs = '0;
  logic [31:0] p_wv = '0;
  int          hi_run = 0;
  bit          free = 1'b1, was_resp = 1'b0, last_g = 1'b0;
  bit          exp_done, exp_grant, c_d = 1'b0, g;
  logic [29:0] c_addr = '0;
  logic [3:0]  c_bs = '0;
  logic        c_we = 1'b0;
  logic [31:0] c_wv = '0, mi = '0, md = '0;
  resp_t       r;

  initial begin
    forever begin
      @(negedge clk);
      exp_done  = p_rst && p_macc && (p_mack || hi_run == TO);
      exp_grant = p_rst && free && (p_i || p_d);
      chk("m_access", 32'(m_access), 32'(p_rst && (exp_grant || (p_macc && !exp_done))));
      chk("ack_any", 32'(i_ack | d_ack), 32'(exp_done));
      chk("ack_excl", 32'(i_ack & d_ack), 32'h0);
      if (!p_rst) begin
        chk("rst_m_addr", 32'(m_addr), 32'h0);
        chk("rst_m_bsel_we", 32'({m_bytesel, m_wr_en}), 32'h0);
        chk("rst_m_wr_val", m_wr_val, 32'h0);
        chk("rst_errors", 32'({i_error, d_error}), 32'h0);
        grant_q.delete(); resp_q.delete();
        last_g = 1'b0; mi = '0; md = '0;
      end else if (exp_grant) begin
        c_d    = (p_i && p_d) ? !last_g : p_d;
        last_g = c_d;
        c_addr = c_d ? p_da : p_ia;
        c_bs   = c_d ? p_bs : 4'hF;
        c_we   = c_d ? p_we : 1'b0;
        c_wv   = p_wv;
        chk(c_d ? "grant_d_addr" : "grant_i_addr", 32'(m_addr), 32'(c_addr));
        chk("grant_bytesel", 32'(m_bytesel), 32'(c_bs));
        chk("grant_wr_en", 32'(m_wr_en), 32'(c_we));
        if (c_d) chk("grant_wr_val", m_wr_val, c_wv);
        grant_q.push_back(c_d);
      end else if (m_access) begin
        chk("m_hold", 32'(m_addr == c_addr && m_bytesel == c_bs && m_wr_en == c_we &&
                          (!c_d || m_wr_val == c_wv)), 32'h1);
      end
      if (i_ack || d_ack) begin
        if (grant_q.size() == 0 || resp_q.size() == 0) begin
          chk("ack_unexpected", 32'(d_ack), 32'h2);
        end else begin
          g = grant_q.pop_front();
          r = resp_q.pop_front();
          chk("ack_client_d", 32'(d_ack), 32'(g));
          chk("ack_error", 32'(g ? d_error : i_error), 32'(r.err));
          if (g) md = r.data; else mi = r.data;
        end
      end
      chk("i_data", i_data, mi);
      chk("d_data", d_data, md);
      if (!p_rst) begin
        free = 1'b1; was_resp = 1'b0;
      end else begin
        if (exp_grant || exp_done) free = 1'b0;
        else if (was_resp) free = 1'b1;
        was_resp = exp_done;
      end
      hi_run = m_access ? hi_run + 1 : 0;
      p_rst = rst; p_i = i_access; p_d = d_access; p_ia = i_addr; p_da = d_addr;
      p_bs = d_bytesel; p_we = d_wr_en; p_wv = d_wr_val; p_macc = m_access; p_mack = m_ack;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit is_d, input bit acc, input logic [29:0] a,
                       input logic [3:0] bs, input bit we, input logic [31:0] wv);
    if (is_d) begin
      d_access = acc; d_addr = a; d_bytesel = bs; d_wr_en = we; d_wr_val = wv;
    end else begin
      i_access = acc; i_addr = a;
    end
  endtask

  task automatic wait_ack(input bit is_d, input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      tick();
      if (is_d ? d_ack : i_ack) got = 1'b1;
    end
    chk(is_d ? "wait_d_ack" : "wait_i_ack", 32'(got), 32'h1);
  endtask

  task automatic xact(input bit is_d, input logic [29:0] a, input logic [3:0] bs,
                      input bit we, input logic [31:0] wv);
    bit got;
    drive(is_d, 1'b1, a, bs, we, wv);
    wait_ack(is_d, 60, got);
    tick();
    drive(is_d, 1'b0, a, bs, we, wv);
  endtask

  task automatic rand_client(input bit is_d, input int n);
    bit got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      drive(is_d, 1'b1, 30'($urandom), 4'($urandom), 1'($urandom), $urandom);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 2)) tick();
        drive(is_d, 1'b0, 30'h0, 4'h0, 1'b0, 32'h0);
      end else begin
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
          tick();
          if (is_d ? d_ack : i_ack) got = 1'b1;
          else if ($urandom_range(0, 3) == 0)
            drive(is_d, 1'b1, 30'($urandom), 4'($urandom), 1'($urandom), $urandom);
        end
        chk("rand_wait_ack", 32'(got), 32'h1);
        tick();
        drive(is_d, 1'b0, 30'h0, 4'h0, 1'b0, 32'h0);
      end
    end
  endtask

  initial begin
    bit got;
    rst = 1'b0;
    drive(1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 30'h0, 4'h0, 1'b0, 32'h0);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Data write, slave acks on the third cycle of m_access.
    plan_q.push_back('{lat: 2, data: 32'h0, err: 1'b0, late: 0});
    xact(1'b1, 30'h100, 4'b0011, 1'b1, 32'hDEADBEEF);
    repeat (2) tick();

    // Instruction read returning data.
    plan_q.push_back('{lat: 1, data: 32'h12345678, err: 1'b0, late: 0});
    xact(1'b0, 30'h40, 4'h0, 1'b0, 32'h0);

    // Slave error, then a clean read acked exactly on the expiry cycle.
    plan_q.push_back('{lat: 0, data: 32'hCAFEF00D, err: 1'b1, late: 0});
    xact(1'b0, 30'h44, 4'h0, 1'b0, 32'h0);
    plan_q.push_back('{lat: TO - 1, data: 32'h0BADF00D, err: 1'b0, late: 0});
    xact(1'b0, 30'h48, 4'h0, 1'b0, 32'h0);

    // Hung slave on a data access, late ack afterwards.
    plan_q.push_back('{lat: NEVER, data: 32'h0, err: 1'b0, late: 3});
    xact(1'b1, 30'h200, 4'hF, 1'b0, 32'h0);
    repeat (6) tick();

    // Simultaneous requests straight out of reset, then back-to-back repeats.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    fork
      repeat (3) xact(1'b0, 30'($urandom), 4'hF, 1'b0, 32'h0);
      repeat (3) xact(1'b1, 30'($urandom), 4'($urandom), 1'($urandom), $urandom);
    join
    repeat (3) tick();

    // Reset while a data transaction is outstanding.
    plan_q.push_back('{lat: NEVER, data: 32'h0, err: 1'b0, late: 0});
    drive(1'b1, 1'b1, 30'h3FF, 4'hA, 1'b1, 32'h5555AAAA);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (m_access) got = 1'b1;
    end
    chk("busy_d_reached", 32'(got), 32'h1);
    repeat (2) tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 30'h77, 4'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 30'h0, 4'h0, 1'b0, 32'h0);
    tick();
    chk("rst_mid_m_access", 32'(m_access), 32'h0);
    chk("rst_mid_acks", 32'({i_ack, d_ack}), 32'h0);
    rst = 1'b1;
    wait_ack(1'b0, 20, got);
    tick();
    drive(1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 32'h0);
    repeat (3) tick();

    // Randomized traffic from both clients with spurious slave acks.
    spur_en = 1'b1;
    fork
      rand_client(1'b0, 60);
      rand_client(1'b1, 60);
    join
    spur_en = 1'b0;
    repeat (30) tick();
    chk("grant_q_drained", 32'(grant_q.size()), 32'h0);
    chk("resp_q_drained", 32'(resp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
